// File: rtl/otp_pkg.sv
// otp_pkg: shared OTP width/timing defaults, burn-kind and controller state types
package otp_pkg;
    localparam int OTP_NUM_WORDS   = 4;
    localparam int OTP_ADDR_W      = 2;
    localparam int OTP_WORD_W      = 8;
    localparam int OTP_BURN_CYCLES = 16;
    typedef enum logic {KIND_PROG, KIND_LOCK} burn_kind_e;
    typedef enum logic {ST_IDLE, ST_BURN} otp_state_e;
endpackage

// File: rtl/otp_fuse_array.sv
// otp_fuse_array: non-resettable fuse bytes and lock fuse, combinational reads, one-cycle commit port (OTP_BLANK_CHECK_EN adds a check read port)
module otp_fuse_array
    import otp_pkg::*;
#(
    parameter int NUM_WORDS = OTP_NUM_WORDS,
    parameter int ADDR_W    = OTP_ADDR_W,
    parameter int WORD_W    = OTP_WORD_W,
    parameter logic [NUM_WORDS*WORD_W-1:0] FUSE_INIT = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
`ifdef OTP_BLANK_CHECK_EN
    input  logic [ADDR_W-1:0] chk_addr,
    output logic [WORD_W-1:0] chk_data,
`endif
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              lock_set,
    output logic              locked
);
    logic [NUM_WORDS*WORD_W-1:0] fuse_q = FUSE_INIT;
    logic                        lock_q = 1'b0;

    function automatic logic [WORD_W-1:0] word_at(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_WORDS) ? fuse_q[int'(a)*WORD_W +: WORD_W] : '0;
    endfunction

    assign rd_data = word_at(rd_addr);
`ifdef OTP_BLANK_CHECK_EN
    assign chk_data = word_at(chk_addr);
`endif
    assign locked = lock_q;

    // Commit: fuse bits only ever go 0->1; lock fuse is one-way; no reset by design
    always_ff @(posedge clk) begin
        if (wr_en)
            fuse_q[int'(wr_addr)*WORD_W +: WORD_W] <= fuse_q[int'(wr_addr)*WORD_W +: WORD_W] | wr_data;
        if (lock_set)
            lock_q <= 1'b1;
    end
endmodule

// File: rtl/otp_fuse_ctrl.sv
// otp_fuse_ctrl: OTP read responder plus slow one-way programming/lock FSM (OTP_BLANK_CHECK_EN rejects programming of non-blank words)
module otp_fuse_ctrl
    import otp_pkg::*;
#(
    parameter int NUM_WORDS   = OTP_NUM_WORDS,
    parameter int ADDR_W      = OTP_ADDR_W,
    parameter int WORD_W      = OTP_WORD_W,
    parameter int BURN_CYCLES = OTP_BURN_CYCLES,
    parameter logic [NUM_WORDS*WORD_W-1:0] FUSE_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              otp_read_en,
    input  logic [ADDR_W-1:0] otp_read_addr,
    output logic [WORD_W-1:0] otp_read_data,
    input  logic              prog_req,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    input  logic              lock_req,
    output logic              prog_ack,
    output logic              prog_busy,
    output logic              prog_done,
    output logic              prog_err,
    output logic              locked
);
    localparam int CNT_W = $clog2(BURN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURN_CYCLES - 1);

    otp_state_e        state_q, state_d;
    burn_kind_e        kind_q, kind_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              done_q;
    logic              wr_en, lock_set, reject;
    logic [WORD_W-1:0] rd_word;
`ifdef OTP_BLANK_CHECK_EN
    logic [WORD_W-1:0] chk_word;
`endif

    otp_fuse_array #(
        .NUM_WORDS(NUM_WORDS),
        .ADDR_W   (ADDR_W),
        .WORD_W   (WORD_W),
        .FUSE_INIT(FUSE_INIT)
    ) u_array (
        .clk     (clk),
        .rd_addr (otp_read_addr),
        .rd_data (rd_word),
`ifdef OTP_BLANK_CHECK_EN
        .chk_addr(prog_addr),
        .chk_data(chk_word),
`endif
        .wr_en   (wr_en),
        .wr_addr (addr_q),
        .wr_data (data_q),
        .lock_set(lock_set),
        .locked  (locked)
    );

    assign otp_read_data = otp_read_en ? rd_word : '0;
    assign prog_busy     = (state_q == ST_BURN);
    assign prog_done     = done_q;
`ifdef OTP_BLANK_CHECK_EN
    assign reject = locked || int'(prog_addr) >= NUM_WORDS || chk_word != '0;
`else
    assign reject = locked || int'(prog_addr) >= NUM_WORDS;
`endif

    // State register; reset aborts any burn before its commit edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_PROG;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= wr_en | lock_set;
        end
    end

    // Accept/reject in IDLE (prog beats lock); count down in BURN and commit at zero
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        prog_ack = 1'b0;
        prog_err = 1'b0;
        wr_en    = 1'b0;
        lock_set = 1'b0;
        if (state_q == ST_IDLE) begin
            if (prog_req) begin
                prog_ack = 1'b1;
                prog_err = reject;
                if (!reject) begin
                    state_d = ST_BURN;
                    kind_d  = KIND_PROG;
                    cnt_d   = CNT_LOAD;
                    addr_d  = prog_addr;
                    data_d  = prog_data;
                end
            end else if (lock_req) begin
                prog_ack = 1'b1;
                if (!locked) begin
                    state_d = ST_BURN;
                    kind_d  = KIND_LOCK;
                    cnt_d   = CNT_LOAD;
                end
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                state_d  = ST_IDLE;
                wr_en    = (kind_q == KIND_PROG);
                lock_set = (kind_q == KIND_LOCK);
            end
        end
    end
endmodule

// File: tb/tb_otp_fuse_ctrl.sv
// tb_otp_fuse_ctrl: randomized self-checking bench against a byte-array/lock-bit model (OTP_BLANK_CHECK_EN enables the blank-check scenario)
module tb_otp_fuse_ctrl;
    localparam int BC = 16;
    localparam logic [31:0] INIT = 32'hA5C3_7E19;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       otp_read_en = 1'b0;
    logic [1:0] otp_read_addr = '0;
    logic [7:0] otp_read_data;
    logic       prog_req = 1'b0;
    logic [1:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic       lock_req = 1'b0;
    logic       prog_ack, prog_busy, prog_done, prog_err, locked;

    int tests = 0;
    int fails = 0;
    logic [7:0] mem_m [4];
    bit lock_m = 1'b0;

    otp_fuse_ctrl #(
        .NUM_WORDS(4), .ADDR_W(2), .WORD_W(8), .BURN_CYCLES(BC), .FUSE_INIT(INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .otp_read_en(otp_read_en), .otp_read_addr(otp_read_addr), .otp_read_data(otp_read_data),
        .prog_req(prog_req), .prog_addr(prog_addr), .prog_data(prog_data), .lock_req(lock_req),
        .prog_ack(prog_ack), .prog_busy(prog_busy), .prog_done(prog_done), .prog_err(prog_err),
        .locked(locked)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reads(input string tag);
        for (int a = 0; a < 4; a++) begin
            next_cycle();
            otp_read_en = 1'b1;
            otp_read_addr = 2'(a);
            #1;
            tests++;
            if (otp_read_data !== mem_m[a]) begin
                fails++;
                $display("FAIL %s read[%0d]: got %h required %h", tag, a, otp_read_data, mem_m[a]);
            end
        end
        otp_read_en = 1'b0;
        tests++;
        if (locked !== lock_m) begin
            fails++;
            $display("FAIL %s locked: got %b required %b", tag, locked, lock_m);
        end
    endtask

    task automatic run_burn(input bit lk, input logic [1:0] a, input logic [7:0] d);
        logic [7:0] old_v, new_v;
        int busy_n = 0;
        int done_at = 0;
        bit rd_bad = 1'b0;
        old_v = mem_m[a];
        new_v = lk ? old_v : (old_v | d);
        next_cycle();
        prog_addr = a;
        prog_data = d;
        prog_req = !lk;
        lock_req = lk;
        otp_read_en = 1'b1;
        otp_read_addr = a;
        #1;
        tests++;
        if (prog_ack !== 1'b1 || prog_err !== 1'b0 || prog_busy !== 1'b0) begin
            fails++;
            $display("FAIL burn_accept: ack=%b err=%b busy=%b required 1 0 0", prog_ack, prog_err, prog_busy);
        end
        for (int k = 1; k <= BC + 5; k++) begin
            next_cycle();
            prog_req = 1'b0;
            lock_req = 1'b0;
            #1;
            if (prog_done === 1'b1) begin
                done_at = k;
                if (otp_read_data !== new_v) rd_bad = 1'b1;
                break;
            end
            if (prog_busy === 1'b1) busy_n++;
            if (otp_read_data !== old_v) rd_bad = 1'b1;
        end
        otp_read_en = 1'b0;
        tests++;
        if (done_at != BC + 1 || busy_n != BC) begin
            fails++;
            $display("FAIL burn_timing: done at T+%0d busy %0d cycles, required T+%0d and %0d", done_at, busy_n, BC + 1, BC);
        end
        tests++;
        if (rd_bad) begin
            fails++;
            $display("FAIL burn_read_during: addr %0d old %h new %h not observed in order", a, old_v, new_v);
        end
        if (done_at != 0) begin
            if (lk) lock_m = 1'b1;
            else mem_m[a] = new_v;
        end
    endtask

    task automatic test_reset();
        for (int a = 0; a < 4; a++) mem_m[a] = INIT[a*8 +: 8];
        rst_n = 1'b0;
        repeat (3) next_cycle();
        otp_read_en = 1'b0;
        #1;
        tests++;
        if ({prog_ack, prog_busy, prog_done, prog_err, locked} !== 5'b0 || otp_read_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: ack busy done err locked=%b rd=%h required 00000 00",
                     {prog_ack, prog_busy, prog_done, prog_err, locked}, otp_read_data);
        end
        next_cycle();
        rst_n = 1'b1;
        check_reads("after_reset");
    endtask

    task automatic test_prog();
        run_burn(1'b0, 2'd1, 8'h81);
        tests++;
        if (mem_m[1] !== 8'hFF) begin
            fails++;
            $display("FAIL prog_model: word1 %h required ff", mem_m[1]);
        end
        check_reads("prog");
    endtask

    task automatic test_reset_abort();
        bit done_seen = 1'b0;
        next_cycle();
        prog_req = 1'b1;
        prog_addr = 2'd0;
        prog_data = 8'h0F;
        repeat (5) next_cycle();
        prog_req = 1'b0;
        #1;
        tests++;
        if (prog_busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_busy: busy %b required 1", prog_busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (prog_busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset_busy: busy %b required 0", prog_busy);
        end
        repeat (2) next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < BC + 4; k++) begin
            next_cycle();
            if (prog_done === 1'b1) done_seen = 1'b1;
        end
        tests++;
        if (done_seen) begin
            fails++;
            $display("FAIL abort_done: done seen 1 required 0");
        end
        check_reads("abort");
        run_burn(1'b0, 2'd0, 8'h0F);
        check_reads("rerun");
        next_cycle();
        rst_n = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        check_reads("persist");
    endtask

    task automatic test_conflict();
        bit ack_seen = 1'b0;
        next_cycle();
        prog_req = 1'b1;
        lock_req = 1'b1;
        prog_addr = 2'd3;
        prog_data = 8'h10;
        #1;
        tests++;
        if (prog_ack !== 1'b1 || prog_err !== 1'b0) begin
            fails++;
            $display("FAIL conflict_ack: ack=%b err=%b required 1 0", prog_ack, prog_err);
        end
        for (int k = 1; k <= BC; k++) begin
            next_cycle();
            prog_req = (k == 3);
            #1;
            if (prog_ack === 1'b1) ack_seen = 1'b1;
        end
        next_cycle();
        prog_req = 1'b0;
        lock_req = 1'b0;
        #1;
        tests++;
        if (ack_seen) begin
            fails++;
            $display("FAIL conflict_ack_in_burn: ack seen 1 required 0");
        end
        tests++;
        if (prog_done !== 1'b1 || locked !== 1'b0) begin
            fails++;
            $display("FAIL conflict_done: done=%b locked=%b required 1 0", prog_done, locked);
        end
        mem_m[3] = mem_m[3] | 8'h10;
        check_reads("conflict");
    endtask

    task automatic test_random();
        run_burn(1'b0, 2'd2, 8'h00);
        for (int i = 0; i < 8; i++) run_burn(1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
        check_reads("random");
    endtask

`ifdef OTP_BLANK_CHECK_EN
    task automatic test_blank_check();
        next_cycle();
        prog_req = 1'b1;
        prog_addr = 2'd2;
        prog_data = 8'h01;
        #1;
        tests++;
        if (prog_ack !== 1'b1 || prog_err !== 1'b1) begin
            fails++;
            $display("FAIL blank_reject: ack=%b err=%b required 1 1", prog_ack, prog_err);
        end
        next_cycle();
        prog_req = 1'b0;
        #1;
        tests++;
        if (prog_busy !== 1'b0) begin
            fails++;
            $display("FAIL blank_busy: busy %b required 0", prog_busy);
        end
        check_reads("blank");
    endtask
`endif

    task automatic test_lock();
        run_burn(1'b1, 2'd0, 8'h00);
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL lock_set: locked %b required 1", locked);
        end
        next_cycle();
        prog_req = 1'b1;
        prog_addr = 2'($urandom_range(0, 3));
        prog_data = 8'hFF;
        #1;
        tests++;
        if (prog_ack !== 1'b1 || prog_err !== 1'b1) begin
            fails++;
            $display("FAIL locked_prog: ack=%b err=%b required 1 1", prog_ack, prog_err);
        end
        next_cycle();
        prog_req = 1'b0;
        #1;
        tests++;
        if (prog_busy !== 1'b0) begin
            fails++;
            $display("FAIL locked_prog_busy: busy %b required 0", prog_busy);
        end
        check_reads("locked");
        next_cycle();
        lock_req = 1'b1;
        #1;
        tests++;
        if (prog_ack !== 1'b1 || prog_err !== 1'b0) begin
            fails++;
            $display("FAIL relock_ack: ack=%b err=%b required 1 0", prog_ack, prog_err);
        end
        next_cycle();
        lock_req = 1'b0;
        #1;
        tests++;
        if (prog_busy !== 1'b0 || prog_done !== 1'b0) begin
            fails++;
            $display("FAIL relock_idle: busy=%b done=%b required 0 0", prog_busy, prog_done);
        end
    endtask

    initial begin
        test_reset();
        test_prog();
        test_reset_abort();
        test_conflict();
        test_random();
`ifdef OTP_BLANK_CHECK_EN
        test_blank_check();
`endif
        test_lock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
